// File: rtl/immgen_pipe.sv
// immgen_pipe: RV32I immediate decoder feeding an elastic STAGES-deep
// valid/ready pipeline that carries imm, format code and a sideband tag.
// Ports: clk_i, rst_i (sync, active-high), flush_i, valid_i/ready_o/inst_i/tag_i
//   upstream, valid_o/ready_i/imm_o/type_o/tag_o downstream.
// Optional: define IMMGEN_PIPE_CHECK_EN to add illegal_o (zeroes imm/type).
module immgen_pipe #(
   parameter int STAGES = 2,
   parameter int TAG_W  = 5,
   parameter int XLEN   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [31:0]      inst_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [2:0]       type_o,
`ifdef IMMGEN_PIPE_CHECK_EN
   output logic             illegal_o,
`endif
   output logic [TAG_W-1:0] tag_o
);

   typedef enum logic [2:0] {
      T_NONE  = 3'd0,
      T_I     = 3'd1,
      T_SHAMT = 3'd2,
      T_S     = 3'd3,
      T_B     = 3'd4,
      T_U     = 3'd5,
      T_J     = 3'd6
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ---------------- decode ----------------
   logic [2:0]      f3;
   logic [31:0]     imm32;
   fmt_e            dtype;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_type;
`ifdef IMMGEN_PIPE_CHECK_EN
   logic            dec_ill;
`endif

   always_comb begin
      f3    = inst_i[14:12];
      imm32 = '0;
      dtype = T_NONE;
      case (inst_i[6:0])
         OP_LOAD, OP_JALR: begin
            dtype = T_I;
            imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         OP_IMM: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
               dtype = T_SHAMT;
               imm32 = {27'b0, inst_i[24:20]};
            end else begin
               dtype = T_I;
               imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            end
         end
         OP_STORE: begin
            dtype = T_S;
            imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         end
         OP_BRANCH: begin
            dtype = T_B;
            imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                     inst_i[30:25], inst_i[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            dtype = T_U;
            imm32 = {inst_i[31:12], 12'b0};
         end
         OP_JAL: begin
            dtype = T_J;
            imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                     inst_i[20], inst_i[30:21], 1'b0};
         end
         default: begin
            dtype = T_NONE;
            imm32 = '0;
         end
      endcase

`ifdef IMMGEN_PIPE_CHECK_EN
      // Shift encodings: bit 25 is shamt[5] (RV64 only); funct7 must be
      // 0000000 or 0100000 for the right shifts.
      dec_ill = (inst_i[1:0] != 2'b11) || (dtype == T_NONE) ||
                ((dtype == T_SHAMT) &&
                 (inst_i[25] ||
                  ((f3 == 3'b101) &&
                   (inst_i[31:26] != 6'b000000) &&
                   (inst_i[31:26] != 6'b010000))));
      if (dec_ill) begin
         dtype = T_NONE;
         imm32 = '0;
      end
`endif

      dec_imm       = {XLEN{imm32[31]}};
      dec_imm[31:0] = imm32;
      dec_type      = dtype;
   end

   // ---------------- pipeline ----------------
   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] ld;
   logic              run;
   logic              in_fire;
   logic [XLEN-1:0]   imm_q  [STAGES];
   logic [XLEN-1:0]   imm_d  [STAGES];
   logic [2:0]        type_q [STAGES];
   logic [2:0]        type_d [STAGES];
   logic [TAG_W-1:0]  tag_q  [STAGES];
   logic [TAG_W-1:0]  tag_d  [STAGES];
`ifdef IMMGEN_PIPE_CHECK_EN
   logic [STAGES-1:0] ill_q, ill_d;
`endif

   always_comb begin
      // A stage can load if it, or any stage after it, has a hole, or the
      // consumer is taking the last entry (bubble collapse).
      run = ready_i;
      ld  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         run   = run | ~v_q[k];
         ld[k] = run;
      end
      ready_o = ld[0];
      in_fire = valid_i & ld[0];

      v_d    = v_q;
      imm_d  = imm_q;
      type_d = type_q;
      tag_d  = tag_q;
`ifdef IMMGEN_PIPE_CHECK_EN
      ill_d  = ill_q;
`endif

      if (ld[0]) v_d[0] = valid_i;
      if (in_fire) begin
         imm_d[0]  = dec_imm;
         type_d[0] = dec_type;
         tag_d[0]  = tag_i;
`ifdef IMMGEN_PIPE_CHECK_EN
         ill_d[0]  = dec_ill;
`endif
      end

      for (int k = 1; k < STAGES; k++) begin
         if (ld[k]) v_d[k] = v_q[k-1];
         if (ld[k] && v_q[k-1]) begin
            imm_d[k]  = imm_q[k-1];
            type_d[k] = type_q[k-1];
            tag_d[k]  = tag_q[k-1];
`ifdef IMMGEN_PIPE_CHECK_EN
            ill_d[k]  = ill_q[k-1];
`endif
         end
      end

      if (flush_i) v_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            imm_q[k]  <= '0;
            type_q[k] <= '0;
            tag_q[k]  <= '0;
         end
`ifdef IMMGEN_PIPE_CHECK_EN
         ill_q <= '0;
`endif
      end else begin
         v_q <= v_d;
         for (int k = 0; k < STAGES; k++) begin
            imm_q[k]  <= imm_d[k];
            type_q[k] <= type_d[k];
            tag_q[k]  <= tag_d[k];
         end
`ifdef IMMGEN_PIPE_CHECK_EN
         ill_q <= ill_d;
`endif
      end
   end

   assign valid_o = v_q[STAGES-1];
   assign imm_o   = imm_q[STAGES-1];
   assign type_o  = type_q[STAGES-1];
   assign tag_o   = tag_q[STAGES-1];
`ifdef IMMGEN_PIPE_CHECK_EN
   assign illegal_o = ill_q[STAGES-1];
`endif

endmodule
